axis_host_arbiter: RTL and testbench

//  Shares the single AXI-Stream command/response port of the toplevelbus Wishbone master between two host links (e.g. SPI and UART).

---
 rtl/axis_host_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_axis_host_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_host_arbiter.sv
// axis_host_arbiter
// Shares one AXI-Stream command/response port pair (toward the Wishbone
// master) between two host links. Arbitration is round-robin at transaction
// granularity: a grant covers a full command packet and then the matching
// response packet. Only the granted host sees the response. A response that
// stalls too long is abandoned, and the bus is released.
//
// Ports
//   i_clk, i_reset            clock, synchronous active-high reset
//   s0_axis_*, s1_axis_*      command streams from host0 / host1 (slave side)
//   m0_axis_*, m1_axis_*      response streams to host0 / host1 (master side)
//   o_cmd_axis_*              command stream to the Wishbone master
//   i_rsp_axis_*              response stream from the Wishbone master
//   o_grant                   one-hot current owner, 00 when idle
//   o_timeout                 1-cycle pulse when a response times out
//   o_rsp_drop                1-cycle pulse per stray response byte discarded
//
// The data paths (o_cmd_*, s*_tready, m*_*, i_rsp_tready) are combinational
// muxes steered by the registered grant. o_grant, o_timeout and o_rsp_drop
// are registered.

module axis_host_arbiter #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_reset,

    // host0 command in
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tvalid,
    input  logic                  s0_axis_tlast,
    output logic                  s0_axis_tready,
    // host0 response out
    output logic [DATA_WIDTH-1:0] m0_axis_tdata,
    output logic                  m0_axis_tvalid,
    output logic                  m0_axis_tlast,
    input  logic                  m0_axis_tready,

    // host1 command in
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tvalid,
    input  logic                  s1_axis_tlast,
    output logic                  s1_axis_tready,
    // host1 response out
    output logic [DATA_WIDTH-1:0] m1_axis_tdata,
    output logic                  m1_axis_tvalid,
    output logic                  m1_axis_tlast,
    input  logic                  m1_axis_tready,

    // shared command out to the Wishbone master
    output logic [DATA_WIDTH-1:0] o_cmd_axis_tdata,
    output logic                  o_cmd_axis_tvalid,
    output logic                  o_cmd_axis_tlast,
    input  logic                  o_cmd_axis_tready,

    // shared response in from the Wishbone master
    input  logic [DATA_WIDTH-1:0] i_rsp_axis_tdata,
    input  logic                  i_rsp_axis_tvalid,
    input  logic                  i_rsp_axis_tlast,
    output logic                  i_rsp_axis_tready,

    // status
    output logic [1:0]            o_grant,
    output logic                  o_timeout,
    output logic                  o_rsp_drop
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t             state;
    logic [1:0]         grant;
    logic               last_grant;   // index of the host served last
    logic [CNT_W-1:0]   tmo_cnt;

    logic               sel;          // index of the granted host
    logic               cmd_valid;
    logic               cmd_last;
    logic               cmd_fire;
    logic               rsp_fire;
    logic               tmo_hit;

    assign sel      = grant[1];
    assign o_grant  = grant;

    // Granted host's command qualifiers, used for the CMD->RSP decision.
    assign cmd_valid = sel ? s1_axis_tvalid : s0_axis_tvalid;
    assign cmd_last  = sel ? s1_axis_tlast  : s0_axis_tlast;
    assign cmd_fire  = (state == ST_CMD) && cmd_valid && o_cmd_axis_tready;

    // Response handshake; outside RSP i_rsp_tready is 1, so this also
    // marks every byte that gets discarded.
    assign rsp_fire  = i_rsp_axis_tvalid && i_rsp_axis_tready;

    assign tmo_hit   = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Stream steering: command path in CMD, response path in RSP.
    always_comb begin
        o_cmd_axis_tdata  = '0;
        o_cmd_axis_tvalid = 1'b0;
        o_cmd_axis_tlast  = 1'b0;
        s0_axis_tready    = 1'b0;
        s1_axis_tready    = 1'b0;

        m0_axis_tdata     = '0;
        m0_axis_tvalid    = 1'b0;
        m0_axis_tlast     = 1'b0;
        m1_axis_tdata     = '0;
        m1_axis_tvalid    = 1'b0;
        m1_axis_tlast     = 1'b0;
        i_rsp_axis_tready = 1'b1;

        case (state)
            ST_CMD: begin
                if (sel) begin
                    o_cmd_axis_tdata  = s1_axis_tdata;
                    o_cmd_axis_tvalid = s1_axis_tvalid;
                    o_cmd_axis_tlast  = s1_axis_tlast;
                    s1_axis_tready    = o_cmd_axis_tready;
                end else begin
                    o_cmd_axis_tdata  = s0_axis_tdata;
                    o_cmd_axis_tvalid = s0_axis_tvalid;
                    o_cmd_axis_tlast  = s0_axis_tlast;
                    s0_axis_tready    = o_cmd_axis_tready;
                end
            end
            ST_RSP: begin
                if (sel) begin
                    m1_axis_tdata     = i_rsp_axis_tdata;
                    m1_axis_tvalid    = i_rsp_axis_tvalid;
                    m1_axis_tlast     = i_rsp_axis_tlast;
                    i_rsp_axis_tready = m1_axis_tready;
                end else begin
                    m0_axis_tdata     = i_rsp_axis_tdata;
                    m0_axis_tvalid    = i_rsp_axis_tvalid;
                    m0_axis_tlast     = i_rsp_axis_tlast;
                    i_rsp_axis_tready = m0_axis_tready;
                end
            end
            default: ;
        endcase
    end

    // Transaction FSM, round-robin arbiter, response timeout and pulses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            grant      <= 2'b00;
            last_grant <= 1'b1;
            tmo_cnt    <= '0;
            o_timeout  <= 1'b0;
            o_rsp_drop <= 1'b0;
        end else begin
            o_timeout  <= 1'b0;
            // Any byte accepted outside RSP goes nowhere.
            o_rsp_drop <= (state != ST_RSP) && rsp_fire;

            case (state)
                ST_IDLE: begin
                    // Tie goes to the host that was not served last.
                    if (s0_axis_tvalid && s1_axis_tvalid) begin
                        grant <= last_grant ? 2'b01 : 2'b10;
                        state <= ST_CMD;
                    end else if (s0_axis_tvalid) begin
                        grant <= 2'b01;
                        state <= ST_CMD;
                    end else if (s1_axis_tvalid) begin
                        grant <= 2'b10;
                        state <= ST_CMD;
                    end
                end

                ST_CMD: begin
                    // No timeout here: a stalled host keeps the bus.
                    if (cmd_fire && cmd_last) begin
                        state   <= ST_RSP;
                        tmo_cnt <= '0;
                    end
                end

                ST_RSP: begin
                    if (rsp_fire) begin
                        tmo_cnt <= '0;
                        if (i_rsp_axis_tlast) begin
                            state      <= ST_IDLE;
                            grant      <= 2'b00;
                            last_grant <= sel;
                        end
                    end else if (tmo_hit) begin
                        // Abandon the response; the host never sees tlast.
                        state      <= ST_IDLE;
                        grant      <= 2'b00;
                        last_grant <= sel;
                        tmo_cnt    <= '0;
                        o_timeout  <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_host_arbiter.sv
module tb_axis_host_arbiter;

    localparam int DW    = 8;
    localparam int TMO   = 16;
    localparam int BOUND = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          i_reset;
    logic [DW-1:0] s0_tdata, s1_tdata, m0_tdata, m1_tdata;
    logic          s0_tvalid, s0_tlast, s0_tready, s1_tvalid, s1_tlast, s1_tready;
    logic          m0_tvalid, m0_tlast, m0_tready, m1_tvalid, m1_tlast, m1_tready;
    logic [DW-1:0] cmd_tdata, rsp_tdata;
    logic          cmd_tvalid, cmd_tlast, cmd_tready;
    logic          rsp_tvalid, rsp_tlast, rsp_tready;
    logic [1:0]    o_grant;
    logic          o_timeout, o_rsp_drop;

    axis_host_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .s0_axis_tdata(s0_tdata), .s0_axis_tvalid(s0_tvalid), .s0_axis_tlast(s0_tlast), .s0_axis_tready(s0_tready),
        .m0_axis_tdata(m0_tdata), .m0_axis_tvalid(m0_tvalid), .m0_axis_tlast(m0_tlast), .m0_axis_tready(m0_tready),
        .s1_axis_tdata(s1_tdata), .s1_axis_tvalid(s1_tvalid), .s1_axis_tlast(s1_tlast), .s1_axis_tready(s1_tready),
        .m1_axis_tdata(m1_tdata), .m1_axis_tvalid(m1_tvalid), .m1_axis_tlast(m1_tlast), .m1_axis_tready(m1_tready),
        .o_cmd_axis_tdata(cmd_tdata), .o_cmd_axis_tvalid(cmd_tvalid), .o_cmd_axis_tlast(cmd_tlast),
        .o_cmd_axis_tready(cmd_tready),
        .i_rsp_axis_tdata(rsp_tdata), .i_rsp_axis_tvalid(rsp_tvalid), .i_rsp_axis_tlast(rsp_tlast),
        .i_rsp_axis_tready(rsp_tready),
        .o_grant(o_grant), .o_timeout(o_timeout), .o_rsp_drop(o_rsp_drop)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Stimulus queues and observed-output logs ({tlast, tdata}).
    logic [7:0] cmdq0[$], cmdq1[$], rspq0[$], rspq1[$];
    logic [8:0] cmd_log[$], m0_log[$], m1_log[$], who_log[$], exp_q[$];

    // Behavioural model: who owns the bus and what phase the transaction is in.
    int   m_phase = 0;   // 0 idle, 1 command, 2 response
    int   m_owner = -1;  // -1 nobody
    int   m_prev  = 1;   // host served most recently
    int   m_wait  = 0;   // response cycles without a byte moving
    logic m_tmo   = 1'b0;
    logic m_drop  = 1'b0;
    logic chk_en  = 1'b0;
    logic rand_rdy = 1'b0;

    logic [1:0]    e_grant;
    logic          e_cv, e_cl, e_r0, e_r1, e_rr, e_mv0, e_mv1, m_hs, own_v, own_l;
    logic [DW-1:0] e_cd;

    // Per-cycle compare, then advance the model to the next cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            e_grant = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
            e_cv = 1'b0; e_cl = 1'b0; e_cd = '0; e_r0 = 1'b0; e_r1 = 1'b0;
            e_rr = 1'b1; e_mv0 = 1'b0; e_mv1 = 1'b0;
            if (m_phase == 1 && m_owner == 0) begin
                e_cv = s0_tvalid; e_cd = s0_tdata; e_cl = s0_tlast; e_r0 = cmd_tready;
            end
            if (m_phase == 1 && m_owner == 1) begin
                e_cv = s1_tvalid; e_cd = s1_tdata; e_cl = s1_tlast; e_r1 = cmd_tready;
            end
            if (m_phase == 2 && m_owner == 0) begin e_mv0 = rsp_tvalid; e_rr = m0_tready; end
            if (m_phase == 2 && m_owner == 1) begin e_mv1 = rsp_tvalid; e_rr = m1_tready; end

            chk("o_grant", 32'(o_grant), 32'(e_grant));
            chk("cmd_tvalid", 32'(cmd_tvalid), 32'(e_cv));
            if (e_cv) chk("cmd_tlast_tdata", 32'({cmd_tlast, cmd_tdata}), 32'({e_cl, e_cd}));
            chk("s0_tready", 32'(s0_tready), 32'(e_r0));
            chk("s1_tready", 32'(s1_tready), 32'(e_r1));
            chk("rsp_tready", 32'(rsp_tready), 32'(e_rr));
            chk("m0_tvalid", 32'(m0_tvalid), 32'(e_mv0));
            chk("m1_tvalid", 32'(m1_tvalid), 32'(e_mv1));
            if (e_mv0) chk("m0_tlast_tdata", 32'({m0_tlast, m0_tdata}), 32'({rsp_tlast, rsp_tdata}));
            if (e_mv1) chk("m1_tlast_tdata", 32'({m1_tlast, m1_tdata}), 32'({rsp_tlast, rsp_tdata}));
            chk("o_timeout", 32'(o_timeout), 32'(m_tmo));
            chk("o_rsp_drop", 32'(o_rsp_drop), 32'(m_drop));

            if (!i_reset) begin
                if (cmd_tvalid && cmd_tready) begin
                    cmd_log.push_back({cmd_tlast, cmd_tdata});
                    who_log.push_back({7'b0, o_grant});
                end
                if (m0_tvalid && m0_tready) m0_log.push_back({m0_tlast, m0_tdata});
                if (m1_tvalid && m1_tready) m1_log.push_back({m1_tlast, m1_tdata});
            end
        end

        if (i_reset) begin
            m_phase = 0; m_owner = -1; m_prev = 1; m_wait = 0; m_tmo = 1'b0; m_drop = 1'b0;
        end else begin
            m_tmo  = 1'b0;
            m_drop = (m_phase != 2) && rsp_tvalid;
            own_v  = (m_owner == 1) ? s1_tvalid : s0_tvalid;
            own_l  = (m_owner == 1) ? s1_tlast  : s0_tlast;
            case (m_phase)
                0: begin
                    if (s0_tvalid && s1_tvalid) m_owner = 1 - m_prev;
                    else if (s0_tvalid)         m_owner = 0;
                    else if (s1_tvalid)         m_owner = 1;
                    if (m_owner >= 0) m_phase = 1;
                end
                1: if (own_v && cmd_tready && own_l) begin m_phase = 2; m_wait = 0; end
                2: begin
                    m_hs = rsp_tvalid && ((m_owner == 1) ? m1_tready : m0_tready);
                    if (m_hs) begin
                        m_wait = 0;
                        if (rsp_tlast) begin m_prev = m_owner; m_owner = -1; m_phase = 0; end
                    end else begin
                        m_wait++;
                        if (m_wait == TMO) begin
                            m_tmo = 1'b1; m_prev = m_owner; m_owner = -1; m_phase = 0; m_wait = 0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Random backpressure on the command sink and host0 response sink.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            cmd_tready = 1'($urandom_range(0, 1));
            m0_tready  = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_pkt(input int h);
        int n;
        logic [7:0] b;
        while ((h == 0 ? cmdq0.size() : cmdq1.size()) > 0) begin
            if (h == 0) begin
                b = cmdq0.pop_front();
                s0_tdata = b; s0_tlast = (cmdq0.size() == 0); s0_tvalid = 1'b1;
            end else begin
                b = cmdq1.pop_front();
                s1_tdata = b; s1_tlast = (cmdq1.size() == 0); s1_tvalid = 1'b1;
            end
            n = 0;
            @(negedge clk);
            while (!(h == 0 ? s0_tready : s1_tready) && n < BOUND) begin n++; @(negedge clk); end
            chk($sformatf("host%0d_cmd_wait", h), 32'(n >= BOUND), 32'd0);
            if (n >= BOUND) begin cmdq0.delete(); cmdq1.delete(); end
            @(posedge clk); #1;
        end
        if (h == 0) begin s0_tvalid = 1'b0; s0_tlast = 1'b0; end
        else        begin s1_tvalid = 1'b0; s1_tlast = 1'b0; end
    endtask

    task automatic send_rsp(input int h);
        int n;
        logic [7:0] b;
        while ((h == 0 ? rspq0.size() : rspq1.size()) > 0) begin
            if (h == 0) begin b = rspq0.pop_front(); rsp_tlast = (rspq0.size() == 0); end
            else        begin b = rspq1.pop_front(); rsp_tlast = (rspq1.size() == 0); end
            rsp_tdata = b; rsp_tvalid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!rsp_tready && n < BOUND) begin n++; @(negedge clk); end
            chk($sformatf("host%0d_rsp_wait", h), 32'(n >= BOUND), 32'd0);
            if (n >= BOUND) begin rspq0.delete(); rspq1.delete(); end
            @(posedge clk); #1;
        end
        rsp_tvalid = 1'b0; rsp_tlast = 1'b0;
    endtask

    // Compare one observed log against exp_q: 0 cmd, 1 m0, 2 m1, 3 grant-per-cmd-byte.
    task automatic cmp_log(input string nm, input int which);
        logic [8:0] q[$];
        case (which)
            0: q = cmd_log;
            1: q = m0_log;
            2: q = m1_log;
            default: q = who_log;
        endcase
        chk({nm, "_len"}, 32'(q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s[%0d]", nm, i), (i < q.size()) ? 32'(q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    endtask

    task automatic reset_dut();
        i_reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_reset = 1'b0;
        cmd_log.delete(); m0_log.delete(); m1_log.delete(); who_log.delete();
    endtask

    int n;

    initial begin
        i_reset = 1'b1;
        s0_tdata = '0; s0_tvalid = 1'b0; s0_tlast = 1'b0;
        s1_tdata = '0; s1_tvalid = 1'b0; s1_tlast = 1'b0;
        m0_tready = 1'b1; m1_tready = 1'b1; cmd_tready = 1'b1;
        rsp_tdata = '0; rsp_tvalid = 1'b0; rsp_tlast = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_grant", 32'(o_grant), 32'd0);
        chk("rst_s_tready", 32'({s0_tready, s1_tready}), 32'd0);
        chk("rst_tvalids", 32'({cmd_tvalid, m0_tvalid, m1_tvalid}), 32'd0);
        chk("rst_pulses", 32'({o_timeout, o_rsp_drop}), 32'd0);
        @(posedge clk); #1;
        reset_dut();

        // 1: host0 alone, 7-byte read and a 5-byte response
        cmdq0 = '{8'hA1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04};
        rspq0 = '{8'hA3, 8'h11, 8'h22, 8'h33, 8'h44};
        send_pkt(0);
        send_rsp(0);
        repeat (2) @(posedge clk); #1;
        exp_q = '{9'h0A1, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h104};
        cmp_log("t1_cmd", 0);
        exp_q = '{9'h001, 9'h001, 9'h001, 9'h001, 9'h001, 9'h001, 9'h001};
        cmp_log("t1_grant", 3);
        exp_q = '{9'h0A3, 9'h011, 9'h022, 9'h033, 9'h144};
        cmp_log("t1_m0", 1);
        exp_q = {};
        cmp_log("t1_m1", 2);

        // 2: simultaneous requests after reset, three rounds of pairs
        reset_dut();
        for (int r = 0; r < 3; r++) begin
            cmdq0 = '{8'hA1, 8'(8'h10 + r)};
            cmdq1 = '{8'hA1, 8'(8'h20 + r)};
            rspq0 = '{8'hA3, 8'(8'h50 + r)};
            rspq1 = '{8'hA3, 8'(8'h60 + r)};
            fork
                begin send_pkt(0); send_rsp(0); end
                begin send_pkt(1); send_rsp(1); end
            join
        end
        repeat (2) @(posedge clk); #1;
        exp_q = '{9'h0A1, 9'h110, 9'h0A1, 9'h120, 9'h0A1, 9'h111, 9'h0A1, 9'h121, 9'h0A1, 9'h112, 9'h0A1, 9'h122};
        cmp_log("t2_cmd", 0);
        exp_q = '{9'h1, 9'h1, 9'h2, 9'h2, 9'h1, 9'h1, 9'h2, 9'h2, 9'h1, 9'h1, 9'h2, 9'h2};
        cmp_log("t2_grant", 3);
        exp_q = '{9'h0A3, 9'h150, 9'h0A3, 9'h151, 9'h0A3, 9'h152};
        cmp_log("t2_m0", 1);
        exp_q = '{9'h0A3, 9'h160, 9'h0A3, 9'h161, 9'h0A3, 9'h162};
        cmp_log("t2_m1", 2);

        // 3: write under random backpressure, host1 requesting meanwhile
        reset_dut();
        cmdq0 = '{8'hA2, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h04, 8'hD0, 8'hD1, 8'hD2, 8'hD3};
        rspq0 = '{8'hA4, 8'h00};
        rspq1 = '{8'hA3, 8'h77};
        rand_rdy = 1'b1;
        fork
            begin send_pkt(0); send_rsp(0); end
            begin
                repeat (3) @(posedge clk); #1;
                cmdq1 = '{8'hA1, 8'h30};
                send_pkt(1); send_rsp(1);
            end
        join
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        cmd_tready = 1'b1; m0_tready = 1'b1;
        repeat (2) @(posedge clk); #1;
        exp_q = '{9'h0A2, 9'h000, 9'h000, 9'h000, 9'h010, 9'h000, 9'h004, 9'h0D0, 9'h0D1, 9'h0D2, 9'h1D3,
                  9'h0A1, 9'h130};
        cmp_log("t3_cmd", 0);
        exp_q = '{9'h0A4, 9'h100};
        cmp_log("t3_m0", 1);
        exp_q = '{9'h0A3, 9'h177};
        cmp_log("t3_m1", 2);

        // 4: no response for host0 -> timeout, then pending host1 is granted
        reset_dut();
        cmdq0 = '{8'hA1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04};
        rspq1 = '{8'hA3, 8'h99};
        fork
            begin
                send_pkt(0);
                n = 0;
                @(negedge clk);
                while (!o_timeout && n < 40) begin n++; @(negedge clk); end
                chk("t4_timeout_delay", 32'(n), 32'd16);
                chk("t4_grant_at_timeout", 32'(o_grant), 32'd0);
                @(negedge clk);
                chk("t4_host1_granted", 32'(o_grant), 32'b10);
                chk("t4_timeout_one_cycle", 32'(o_timeout), 32'd0);
            end
            begin
                repeat (3) @(posedge clk); #1;
                cmdq1 = '{8'hA1, 8'h40};
                send_pkt(1); send_rsp(1);
            end
        join
        repeat (2) @(posedge clk); #1;
        exp_q = {};
        cmp_log("t4_m0", 1);
        exp_q = '{9'h0A3, 9'h199};
        cmp_log("t4_m1", 2);

        // 5: stray response byte while idle
        rsp_tdata = 8'h5A; rsp_tvalid = 1'b1; rsp_tlast = 1'b1;
        @(negedge clk);
        chk("t5_rsp_tready", 32'(rsp_tready), 32'd1);
        chk("t5_m_tvalid", 32'({m0_tvalid, m1_tvalid}), 32'd0);
        @(posedge clk); #1;
        rsp_tvalid = 1'b0; rsp_tlast = 1'b0;
        @(negedge clk);
        chk("t5_drop_pulse", 32'(o_rsp_drop), 32'd1);
        @(negedge clk);
        chk("t5_drop_cleared", 32'(o_rsp_drop), 32'd0);
        @(posedge clk); #1;

        // 6: reset in the middle of a command packet
        s0_tdata = 8'hA1; s0_tlast = 1'b0; s0_tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s0_tready && n < BOUND) begin n++; @(negedge clk); end
        chk("t6_grant_wait", 32'(n >= BOUND), 32'd0);
        @(posedge clk); #1;
        s0_tdata = 8'h00;
        @(posedge clk); #1;
        s0_tdata = 8'h00; i_reset = 1'b1;
        @(posedge clk); #1;
        i_reset = 1'b0; s0_tvalid = 1'b0;
        @(negedge clk);
        chk("t6_grant_after_reset", 32'(o_grant), 32'd0);
        chk("t6_s_tready_after_reset", 32'({s0_tready, s1_tready}), 32'd0);
        chk("t6_cmd_tvalid_after_reset", 32'(cmd_tvalid), 32'd0);
        repeat (2) @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
